// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE output-side datapath: lane geometry,
// the unpacker state encoding and a small word-count helper.
package pe_pkg;

    localparam int LANES      = 4;
    localparam int LANE_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Number of packed words needed to carry a given psum count.
    function automatic int unsigned ceilDiv4(input int unsigned value);
        return (value + 32'd3) / 32'd4;
    endfunction

endpackage

// File: rtl/opsum_unpacker.sv
// Drains 4-psum packed words from the PE opsum FIFO and serializes them into
// a 16-bit valid/ready stream, counting p*n*F psums and tagging the final one.
module opsum_unpacker
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int DATA_WIDTH_PSUM = 64,
    parameter int F_WIDTH         = 6,
    parameter int n_WIDTH         = 3,
    parameter int p_WIDTH         = 5,
    parameter int CNT_WIDTH       = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       configure,
    input  logic [F_WIDTH-1:0]         F,
    input  logic [n_WIDTH-1:0]         n,
    input  logic [p_WIDTH-1:0]         p,
    output logic                       busy,
    output logic                       done,
    input  logic [DATA_WIDTH_PSUM-1:0] opsum,
    input  logic                       opsum_fifo_empty,
    output logic                       pop_opsum,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    state_t                     r_state;
    state_t                     w_stateNext;
    logic [CNT_WIDTH-1:0]       r_remaining;
    logic [DATA_WIDTH_PSUM-1:0] r_word;
    logic [LANE_WIDTH-1:0]      r_lane;
    logic [LANE_WIDTH-1:0]      r_lastLane;
    logic                       r_done;

    logic [CNT_WIDTH-1:0]       w_total;
    logic                       w_load;
    logic                       w_pop;
    logic                       w_accept;
    logic                       w_wordEnd;
    logic                       w_doneNext;
    logic [LANE_WIDTH-1:0]      w_firstLastLane;

    // The product fits CNT_WIDTH by construction, so a single-cycle multiply
    // is sampled only on the accepting edge and busy needs no extra latency.
    assign w_total   = CNT_WIDTH'(p) * CNT_WIDTH'(n) * CNT_WIDTH'(F);

    assign w_load    = (r_state == IDLE)  && enable && configure;
    assign w_pop     = (r_state == FETCH) && enable && !opsum_fifo_empty;
    assign w_accept  = (r_state == DRAIN) && enable && out_ready;
    assign w_wordEnd = (r_lane == r_lastLane);

    // A partial final word only carries the remaining psums; its unused lanes are skipped.
    assign w_firstLastLane = (r_remaining >= CNT_WIDTH'(LANES))
                           ? LANE_WIDTH'(LANES - 1)
                           : (r_remaining[LANE_WIDTH-1:0] - LANE_WIDTH'(1));

    always_comb begin
        w_stateNext = r_state;
        w_doneNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    if (w_total != '0) begin
                        w_stateNext = FETCH;
                    end else begin
                        w_doneNext = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (w_pop) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (w_accept && w_wordEnd) begin
                    if (r_remaining == CNT_WIDTH'(1)) begin
                        w_stateNext = IDLE;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_stateNext = FETCH;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_word      <= '0;
            r_lane      <= '0;
            r_lastLane  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_done  <= w_doneNext;

            if (w_load) begin
                r_remaining <= w_total;
            end else if (w_accept) begin
                r_remaining <= r_remaining - CNT_WIDTH'(1);
            end

            // The lane index stays on the last lane after a word so out_data holds through FETCH.
            if (w_pop) begin
                r_word     <= opsum;
                r_lane     <= '0;
                r_lastLane <= w_firstLastLane;
            end else if (w_accept && !w_wordEnd) begin
                r_lane <= r_lane + LANE_WIDTH'(1);
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign pop_opsum = w_pop;
    assign out_valid = (r_state == DRAIN);
    assign out_last  = (r_state == DRAIN) && (r_remaining == CNT_WIDTH'(1));
    assign out_data  = r_word[r_lane*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: tb/tb_opsum_unpacker.sv
// Self-checking bench for opsum_unpacker: a queue-based FIFO model feeds packed
// words, and the captured psum stream is compared against the words in lane order.
module tb_opsum_unpacker;

    typedef struct {
        int p;
        int n;
        int f;
        int expTotal;
        int expPops;
        int randomMode;
        int reconfCycle;
    } layer_t;

    localparam logic [63:0] GUARD_WORD = 64'hDEAD_BEEF_0BAD_F00D;
    localparam int          NUM_LAYERS = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        configure;
    logic [5:0]  F;
    logic [2:0]  n;
    logic [4:0]  p;
    logic        busy;
    logic        done;
    logic [63:0] opsum;
    logic        opsum_fifo_empty;
    logic        pop_opsum;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [63:0] fifoQ[$];
    logic [63:0] srcWords[$];
    logic [15:0] gotData[$];
    logic        gotLast[$];
    int          popCount;
    int          doneCount;
    int          violations;
    int          vectors;
    int          miscompares;

    logic        sPop;
    logic        sValid;
    logic        sReady;
    logic        sEnable;
    logic        sLast;
    logic        sBusy;
    logic        sDone;
    logic [15:0] sData;
    logic        prevHold;
    logic        prevLast;
    logic [15:0] prevData;

    layer_t      layers[NUM_LAYERS];

    always #5 clk = ~clk;

    opsum_unpacker dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .configure        (configure),
        .F                (F),
        .n                (n),
        .p                (p),
        .busy             (busy),
        .done             (done),
        .opsum            (opsum),
        .opsum_fifo_empty (opsum_fifo_empty),
        .pop_opsum        (pop_opsum),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last)
    );

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic refreshFifo();
        opsum            = (fifoQ.size() > 0) ? fifoQ[0] : 64'd0;
        opsum_fifo_empty = (fifoQ.size() == 0);
    endtask

    // One clock: sample at the falling edge, then update the FIFO/capture models after the rising edge.
    task automatic tick();
        @(negedge clk);
        sPop    = pop_opsum;
        sValid  = out_valid;
        sReady  = out_ready;
        sEnable = enable;
        sLast   = out_last;
        sBusy   = busy;
        sDone   = done;
        sData   = out_data;
        if (prevHold && reset && !(out_valid && out_data == prevData && out_last == prevLast)) violations++;
        if (pop_opsum && opsum_fifo_empty) violations++;
        prevHold = out_valid && !(out_ready && enable);
        prevData = out_data;
        prevLast = out_last;
        @(posedge clk);
        #1;
        if (sPop) begin
            popCount++;
            if (fifoQ.size() > 0) fifoQ.delete(0);
        end
        if (sValid && sReady && sEnable) begin
            gotData.push_back(sData);
            gotLast.push_back(sLast);
        end
        if (sDone) doneCount++;
        refreshFifo();
    endtask

    task automatic clearCapture();
        gotData.delete();
        gotLast.delete();
        fifoQ.delete();
        popCount   = 0;
        doneCount  = 0;
        violations = 0;
        prevHold   = 1'b0;
        refreshFifo();
    endtask

    task automatic startLayer(input int cfgP, input int cfgN, input int cfgF);
        p         = 5'(cfgP);
        n         = 3'(cfgN);
        F         = 6'(cfgF);
        configure = 1'b1;
        tick();
        configure = 1'b0;
    endtask

    task automatic drainToDone(input string tag, input int budget);
        int cyc;
        cyc       = 0;
        enable    = 1'b1;
        out_ready = 1'b1;
        while (doneCount == 0 && cyc < budget) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        checkOutput({tag, " done-count"}, doneCount, 1);
    endtask

    // Reference: psum k is lane k%4 of word k/4, and only psum total-1 carries last.
    task automatic checkStream(input string tag, input int expTotal, input int expPops);
        int          errs;
        int          lastCount;
        int          lastPos;
        logic [63:0] w;
        logic [15:0] e;
        errs      = 0;
        lastCount = 0;
        lastPos   = -1;
        checkOutput({tag, " psum-count"}, gotData.size(), expTotal);
        for (int k = 0; k < gotData.size(); k++) begin
            if (k < expTotal) begin
                w = srcWords[k / 4];
                e = w[(k % 4) * 16 +: 16];
                if (gotData[k] !== e) errs++;
            end
            if (gotLast[k]) begin
                lastCount++;
                lastPos = k;
            end
        end
        checkOutput({tag, " stream-errors"}, errs, 0);
        checkOutput({tag, " last-count"}, lastCount, (expTotal > 0) ? 1 : 0);
        checkOutput({tag, " last-position"}, lastPos, expTotal - 1);
        checkOutput({tag, " pops"}, popCount, expPops);
        checkOutput({tag, " busy-end"}, sBusy, 1'b0);
        checkOutput({tag, " valid-end"}, sValid, 1'b0);
        checkOutput({tag, " hold-violations"}, violations, 0);
    endtask

    task automatic applyStimulus(input layer_t cfg, input string tag);
        int   nWords;
        int   wi;
        int   cyc;
        logic firstBusy;
        logic guardPushed;
        nWords      = (cfg.expTotal + 3) / 4;
        wi          = 0;
        cyc         = 0;
        firstBusy   = 1'b0;
        guardPushed = 1'b0;
        clearCapture();
        if (cfg.randomMode == 0) begin
            for (int j = 0; j < nWords; j++) fifoQ.push_back(srcWords[j]);
            fifoQ.push_back(GUARD_WORD);
            guardPushed = 1'b1;
            wi          = nWords;
        end
        refreshFifo();
        enable    = 1'b1;
        out_ready = 1'b1;
        startLayer(cfg.p, cfg.n, cfg.f);
        while (doneCount == 0 && cyc < 8000) begin
            if (cfg.randomMode != 0) begin
                if (wi < nWords && $urandom_range(0, 2) != 0) begin
                    fifoQ.push_back(srcWords[wi]);
                    wi++;
                end else if (wi == nWords && !guardPushed) begin
                    fifoQ.push_back(GUARD_WORD);
                    guardPushed = 1'b1;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                enable    = ($urandom_range(0, 7) != 0);
            end
            if (cyc == cfg.reconfCycle) begin
                configure = 1'b1;
                p         = 5'd2;
            end
            refreshFifo();
            tick();
            configure = 1'b0;
            if (cyc == 0) firstBusy = sBusy;
            cyc++;
        end
        drainToDone(tag, 100);
        checkOutput({tag, " busy-after-configure"}, firstBusy, cfg.expTotal > 0);
        checkStream(tag, cfg.expTotal, cfg.expPops);
    endtask

    initial begin
        int          cyc;
        int          bad;
        logic [63:0] laneWord;
        layer_t      postReset;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        enable      = 1'b0;
        configure   = 1'b0;
        F           = '0;
        n           = '0;
        p           = '0;
        out_ready   = 1'b0;
        clearCapture();

        //            p   n   F  total pops rnd reconf
        layers[0] = '{1,  1,  5,     5,   2,  0,  -1};
        layers[1] = '{16, 1, 55,   880, 220,  1,  -1};
        layers[2] = '{3,  2,  7,    42,  11,  1,  -1};
        layers[3] = '{1,  1,  1,     1,   1,  1,  -1};
        layers[4] = '{2,  3,  1,     6,   2,  1,  -1};
        layers[5] = '{5,  7,  9,   315,  79,  1,  -1};
        layers[6] = '{1,  1,  0,     0,   0,  0,  -1};
        layers[7] = '{1,  1,  8,     8,   2,  0,   3};
        layers[8] = '{0,  7, 63,     0,   0,  0,  -1};
        layers[9] = '{31, 7,  4,   868, 217,  1,  -1};

        repeat (3) tick();
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset done", done, 1'b0);
        checkOutput("reset pop", pop_opsum, 1'b0);
        checkOutput("reset valid", out_valid, 1'b0);
        checkOutput("reset last", out_last, 1'b0);
        checkOutput("reset data", out_data, 16'h0000);
        reset = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < NUM_LAYERS; i++) begin
            srcWords.delete();
            if (i == 0) begin
                srcWords.push_back(64'h0004_0003_0002_0001);
                srcWords.push_back(64'h0000_0000_0000_AAAA);
            end else begin
                for (int j = 0; j < (layers[i].expTotal + 3) / 4; j++) srcWords.push_back({$urandom, $urandom});
            end
            applyStimulus(layers[i], $sformatf("layer%0d", i));
        end

        // Backpressure on lane 2 of the second word.
        clearCapture();
        srcWords.delete();
        for (int j = 0; j < 3; j++) srcWords.push_back({$urandom, $urandom});
        for (int j = 0; j < 3; j++) fifoQ.push_back(srcWords[j]);
        refreshFifo();
        enable    = 1'b1;
        out_ready = 1'b1;
        startLayer(1, 1, 12);
        cyc = 0;
        while (gotData.size() < 6 && cyc < 60) begin
            tick();
            cyc++;
        end
        checkOutput("bp reach-lane2", gotData.size(), 6);
        out_ready = 1'b0;
        laneWord  = srcWords[1];
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("bp hold-valid", sValid, 1'b1);
            checkOutput("bp hold-data", sData, laneWord[47:32]);
            checkOutput("bp hold-no-pop", sPop, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("bp lane3-data", sData, laneWord[63:48]);
        checkOutput("bp lane3-no-pop", sPop, 1'b0);
        drainToDone("bp", 200);
        checkStream("bp", 12, 3);

        // FIFO runs dry for 10 cycles between words.
        clearCapture();
        srcWords.delete();
        for (int j = 0; j < 2; j++) srcWords.push_back({$urandom, $urandom});
        fifoQ.push_back(srcWords[0]);
        refreshFifo();
        enable    = 1'b1;
        out_ready = 1'b1;
        startLayer(1, 1, 8);
        cyc = 0;
        while (gotData.size() < 4 && cyc < 40) begin
            tick();
            cyc++;
        end
        checkOutput("gap word0-drained", gotData.size(), 4);
        bad = 0;
        repeat (10) begin
            tick();
            if (sPop || sValid) bad++;
        end
        checkOutput("gap idle-outputs", bad, 0);
        checkOutput("gap busy-held", sBusy, 1'b1);
        fifoQ.push_back(srcWords[1]);
        refreshFifo();
        tick();
        checkOutput("gap pop", sPop, 1'b1);
        tick();
        laneWord = srcWords[1];
        checkOutput("gap first-valid", sValid, 1'b1);
        checkOutput("gap lane0-data", sData, laneWord[15:0]);
        drainToDone("gap", 100);
        checkStream("gap", 8, 2);

        // Asynchronous reset while draining lane 1.
        clearCapture();
        srcWords.delete();
        for (int j = 0; j < 2; j++) srcWords.push_back({$urandom, $urandom});
        for (int j = 0; j < 2; j++) fifoQ.push_back(srcWords[j]);
        refreshFifo();
        enable    = 1'b1;
        out_ready = 1'b1;
        startLayer(1, 1, 8);
        cyc = 0;
        while (gotData.size() < 1 && cyc < 20) begin
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        tick();
        laneWord = srcWords[0];
        checkOutput("rst lane1-valid", sValid, 1'b1);
        checkOutput("rst lane1-data", sData, laneWord[31:16]);
        reset = 1'b0;
        #1;
        checkOutput("rst async-ctrl", {busy, done, pop_opsum, out_valid, out_last}, 5'b00000);
        checkOutput("rst async-data", out_data, 16'h0000);
        repeat (2) tick();
        reset = 1'b1;
        srcWords.delete();
        srcWords.push_back({$urandom, $urandom});
        postReset = '{1, 1, 4, 4, 1, 0, -1};
        applyStimulus(postReset, "post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
